// File: rtl/ahb_addr_decoder12_if.sv
// Bus-side signals of the 12-slot AHB-Lite address decoder.
// The master modport is the view of whoever drives the address phase.
// The slave modport is the decoder's own view.
interface ahb_addr_decoder12_if #(
    parameter int AW = 32
);
    logic [AW-1:0] haddr;
    logic [1:0]    htrans;
    logic          hready;
    logic [11:0]   hsel;
    logic          hsel_def;
    logic [11:0]   dsel;
    logic          dsel_def;
    logic          def_hreadyout;
    logic          def_hresp;

    modport master (
        output haddr, htrans, hready,
        input  hsel, hsel_def, dsel, dsel_def, def_hreadyout, def_hresp
    );

    modport slave (
        input  haddr, htrans, hready,
        output hsel, hsel_def, dsel, dsel_def, def_hreadyout, def_hresp
    );
endinterface

// File: rtl/ahb_addr_decoder12.sv
// Address decoder and data-phase select register for a 12-slot AHB-Lite
// interconnect.
// It also contains the built-in default slave, which answers unmapped
// NONSEQ/SEQ transfers with the two-cycle ERROR response.
module ahb_addr_decoder12 #(
    parameter int          AW     = 32,
    parameter int          RS     = 28,
    parameter logic [11:0] SLV_EN = 12'hFFF
) (
    input  logic                hclk,
    input  logic                hreset,
    ahb_addr_decoder12_if.slave bus
);
    // Slot 12..15 are never populated; padding the mask lets the slot index it directly.
    localparam logic [15:0] EN16 = {4'b0000, SLV_EN};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ERR1 = 2'd1,
        ERR2 = 2'd2
    } def_state_t;

    def_state_t    state;
    logic [AW-1:0] addr;
    logic [3:0]    slot;
    logic          hit;
    logic [11:0]   hsel_dec;
    logic          accept_err;
    logic          unused_bits;

    assign addr = bus.haddr;
    assign slot = addr[RS+3:RS];

    // Only the region bits and htrans[1] take part in decoding.
    assign unused_bits = ^{addr, bus.htrans[0]};

    // Address-phase decode: one-hot on a populated slot, otherwise the default slave.
    always_comb begin
        hit      = (slot < 4'd12) && EN16[slot];
        hsel_dec = hit ? (12'b1 << slot) : 12'h000;
    end

    assign bus.hsel     = hsel_dec;
    assign bus.hsel_def = ~hit;

    // An active transfer to an unmapped region is only taken once the bus is ready.
    assign accept_err = bus.hready && !hit && bus.htrans[1];

    // Data-phase selects follow the address phase on every accepted cycle and hold on a stall.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            bus.dsel     <= 12'h000;
            bus.dsel_def <= 1'b1;
        end else if (bus.hready) begin
            bus.dsel     <= hsel_dec;
            bus.dsel_def <= ~hit;
        end
    end

    // Default slave: OKAY when idle, otherwise wait-ERROR (ERR1) followed by ready-ERROR (ERR2).
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state             <= IDLE;
            bus.def_hreadyout <= 1'b1;
            bus.def_hresp     <= 1'b0;
        end else begin
            case (state)
                IDLE, ERR2: begin
                    if (accept_err) begin
                        state             <= ERR1;
                        bus.def_hreadyout <= 1'b0;
                        bus.def_hresp     <= 1'b1;
                    end else begin
                        state             <= IDLE;
                        bus.def_hreadyout <= 1'b1;
                        bus.def_hresp     <= 1'b0;
                    end
                end
                ERR1: begin
                    state             <= ERR2;
                    bus.def_hreadyout <= 1'b1;
                    bus.def_hresp     <= 1'b1;
                end
                default: begin
                    state             <= IDLE;
                    bus.def_hreadyout <= 1'b1;
                    bus.def_hresp     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_addr_decoder12.sv
// Bench for ahb_addr_decoder12: one fully populated instance and one with slot 0 absent.
// Both instances share clock, reset and stimulus.
module tb_ahb_addr_decoder12;
    logic hclk;
    logic hreset;

    ahb_addr_decoder12_if #(.AW(32)) bus_a ();
    ahb_addr_decoder12_if #(.AW(32)) bus_b ();

    ahb_addr_decoder12 #(.AW(32), .RS(28), .SLV_EN(12'hFFF)) dut_a (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus_a.slave)
    );

    ahb_addr_decoder12 #(.AW(32), .RS(28), .SLV_EN(12'hFFE)) dut_b (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus_b.slave)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [11:0] o_hsel [2];
    logic [11:0] o_dsel [2];
    logic        o_hdef [2];
    logic        o_ddef [2];
    logic        o_rdy  [2];
    logic        o_resp [2];

    assign o_hsel[0] = bus_a.hsel;
    assign o_hsel[1] = bus_b.hsel;
    assign o_dsel[0] = bus_a.dsel;
    assign o_dsel[1] = bus_b.dsel;
    assign o_hdef[0] = bus_a.hsel_def;
    assign o_hdef[1] = bus_b.hsel_def;
    assign o_ddef[0] = bus_a.dsel_def;
    assign o_ddef[1] = bus_b.dsel_def;
    assign o_rdy[0]  = bus_a.def_hreadyout;
    assign o_rdy[1]  = bus_b.def_hreadyout;
    assign o_resp[0] = bus_a.def_hresp;
    assign o_resp[1] = bus_b.def_hresp;

    // Reference model state.
    // err_left counts the data-phase cycles of an error response still to be shown.
    logic [11:0] en_mask  [2] = '{12'hFFF, 12'hFFE};
    logic [11:0] exp_dsel [2];
    logic        exp_ddef [2];
    int          err_left [2];

    function automatic logic [11:0] ref_hsel(input logic [31:0] a, input logic [11:0] en);
        int unsigned region;
        region = a / 32'h1000_0000;
        if (region < 12 && ((en >> region) & 12'h001) == 12'h001)
            return 12'(1 << region);
        return 12'h000;
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            exp_dsel[k] = 12'h000;
            exp_ddef[k] = 1'b1;
            err_left[k] = 0;
        end
    endtask

    task automatic check_regs(input string ph);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s_dsel%0d", ph, k), 32'(o_dsel[k]), 32'(exp_dsel[k]));
            check($sformatf("%s_dsel_def%0d", ph, k), 32'(o_ddef[k]), 32'(exp_ddef[k]));
            check($sformatf("%s_hreadyout%0d", ph, k), 32'(o_rdy[k]), 32'(err_left[k] != 2));
            check($sformatf("%s_hresp%0d", ph, k), 32'(o_resp[k]), 32'(err_left[k] != 0));
        end
    endtask

    // One bus cycle: drive at the falling edge, check decode, then check registered state after the rising edge.
    task automatic cycle(input logic [31:0] a, input logic [1:0] t, input logic r);
        logic [11:0] dec [2];
        @(negedge hclk);
        bus_a.haddr = a; bus_a.htrans = t; bus_a.hready = r;
        bus_b.haddr = a; bus_b.htrans = t; bus_b.hready = r;
        #1;
        for (int k = 0; k < 2; k++) begin
            dec[k] = ref_hsel(a, en_mask[k]);
            check($sformatf("hsel%0d", k), 32'(o_hsel[k]), 32'(dec[k]));
            check($sformatf("hsel_def%0d", k), 32'(o_hdef[k]), 32'(dec[k] == 12'h000));
        end
        @(posedge hclk);
        for (int k = 0; k < 2; k++) begin
            if (err_left[k] == 2)
                err_left[k] = 1;
            else if (r && dec[k] == 12'h000 && t[1])
                err_left[k] = 2;
            else
                err_left[k] = 0;
            if (r) begin
                exp_dsel[k] = dec[k];
                exp_ddef[k] = (dec[k] == 12'h000);
            end
        end
        #1;
        check_regs("dp");
    endtask

    // Reset raised between edges; outputs must react without waiting for a clock edge.
    task automatic reset_mid();
        #2;
        hreset = 1'b1;
        #1;
        model_reset();
        check_regs("rst");
        @(posedge hclk);
        #1;
        hreset = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int unsigned slot;

        hreset = 1'b1;
        bus_a.haddr = 32'h0; bus_a.htrans = 2'b00; bus_a.hready = 1'b1;
        bus_b.haddr = 32'h0; bus_b.htrans = 2'b00; bus_b.hready = 1'b1;
        model_reset();
        #1;
        check_regs("por");
        @(posedge hclk);
        #1;
        hreset = 1'b0;

        // Mapped access to slot 3.
        cycle(32'h3000_0000, 2'b10, 1'b1);
        check("map_dsel", 32'(bus_a.dsel), 32'h008);
        check("map_dsel_def", 32'(bus_a.dsel_def), 32'h0);

        // Reset in the middle of a cycle with a non-reset dsel.
        reset_mid();
        cycle(32'h3000_0000, 2'b10, 1'b1);

        // Stall: dsel holds slot 3 while slot 5 waits on hready.
        for (int i = 0; i < 3; i++) cycle(32'h5000_0000, 2'b10, 1'b0);
        check("stall_hold", 32'(bus_a.dsel), 32'h008);
        cycle(32'h5000_0000, 2'b10, 1'b1);
        check("stall_release", 32'(bus_a.dsel), 32'h020);

        // Unmapped NONSEQ: ERR1 then ERR2 then IDLE.
        cycle(32'hC000_0000, 2'b10, 1'b1);
        check("err1_ready", 32'(bus_a.def_hreadyout), 32'h0);
        check("err1_resp", 32'(bus_a.def_hresp), 32'h1);
        cycle(32'h0000_0000, 2'b00, 1'b0);
        check("err2_ready", 32'(bus_a.def_hreadyout), 32'h1);
        check("err2_resp", 32'(bus_a.def_hresp), 32'h1);
        cycle(32'h0000_0000, 2'b00, 1'b1);
        check("idle_resp", 32'(bus_a.def_hresp), 32'h0);

        // Back-to-back errors: a new unmapped NONSEQ during ERR2.
        cycle(32'hD000_0000, 2'b10, 1'b1);
        cycle(32'h0000_0000, 2'b00, 1'b0);
        cycle(32'hE000_0000, 2'b10, 1'b1);
        check("b2b_ready", 32'(bus_a.def_hreadyout), 32'h0);
        check("b2b_resp", 32'(bus_a.def_hresp), 32'h1);
        cycle(32'h0000_0000, 2'b00, 1'b0);
        cycle(32'h0000_0000, 2'b00, 1'b1);

        // Disabled slot 0 on the second instance: IDLE is OKAY, SEQ gives an error.
        cycle(32'h0000_0010, 2'b00, 1'b1);
        check("dis_dsel_def", 32'(bus_b.dsel_def), 32'h1);
        check("dis_idle_resp", 32'(bus_b.def_hresp), 32'h0);
        cycle(32'h0000_0010, 2'b11, 1'b1);
        check("dis_err1", 32'({bus_b.def_hreadyout, bus_b.def_hresp}), 32'h1);
        cycle(32'h0000_0010, 2'b00, 1'b0);
        check("dis_err2", 32'({bus_b.def_hreadyout, bus_b.def_hresp}), 32'h3);
        cycle(32'h0000_0010, 2'b00, 1'b1);

        // Reset during ERR1 abandons the error, then slot 11 decodes normally.
        cycle(32'hF000_0000, 2'b10, 1'b1);
        reset_mid();
        check("rst_err_ready", 32'(bus_a.def_hreadyout), 32'h1);
        cycle(32'hB000_0000, 2'b10, 1'b1);
        check("slot11_dsel", 32'(bus_a.dsel), 32'h800);

        // Random traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            slot = $urandom_range(0, 15);
            a = ($urandom() & 32'h0FFF_FFFF) | (slot << 28);
            if ($urandom_range(0, 60) == 0)
                reset_mid();
            cycle(a, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
